// File: rtl/comparator_pkg.sv
// Shared types and helpers for the bit-serial magnitude comparator.
package comparator_pkg;

    localparam int CMP_MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } cmp_state_t;

    typedef struct packed {
        logic eq;
        logic gt;
        logic lt;
    } cmp_result_t;

    // Verdict at the last accepted pair: an earlier decision wins, otherwise the last pair decides.
    function automatic cmp_result_t final_result(
        input logic decided,
        input logic pend_gt,
        input logic pend_lt,
        input logic diff,
        input logic a_bit,
        input logic b_bit
    );
        cmp_result_t r;
        if (decided) begin
            r = '{eq: 1'b0, gt: pend_gt, lt: pend_lt};
        end else begin
            r = '{eq: ~diff, gt: diff & a_bit, lt: diff & b_bit};
        end
        return r;
    endfunction

endpackage

// File: rtl/xorgate.sv
// 1-bit XOR difference cell of the comparator datapath.
module xorgate (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a ^ b;
endmodule

// File: rtl/serial_comparator.sv
// MSB-first bit-serial unsigned comparator; the first differing bit pair fixes the verdict,
// which is published on the flags only once all WIDTH pairs have been consumed.
module serial_comparator
    import comparator_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic bit_valid,
    input  logic a_bit,
    input  logic b_bit,
    output logic busy,
    output logic done,
    output logic eq,
    output logic gt,
    output logic lt
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] COUNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(1);

    cmp_state_t       state;
    cmp_state_t       next_state;
    logic [CNT_W-1:0] count;
    logic             decided;
    logic             pend_gt;
    logic             pend_lt;
    cmp_result_t      result;
    logic             diff;
    logic             accept;
    logic             last_pair;

    xorgate u_diff (
        .a (a_bit),
        .b (b_bit),
        .y (diff)
    );

    assign accept    = (state == SHIFT) && bit_valid;
    assign last_pair = accept && (count == COUNT_LAST);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = SHIFT;
            SHIFT:   if (last_pair) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            decided <= 1'b0;
            pend_gt <= 1'b0;
            pend_lt <= 1'b0;
            result  <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && start) begin
                count   <= COUNT_LOAD;
                decided <= 1'b0;
                pend_gt <= 1'b0;
                pend_lt <= 1'b0;
                result  <= '0;
            end
            if (accept) begin
                count <= count - 1'b1;
                if (!decided && diff) begin
                    decided <= 1'b1;
                    pend_gt <= a_bit;
                    pend_lt <= b_bit;
                end
                if (last_pair) begin
                    result <= final_result(decided, pend_gt, pend_lt, diff, a_bit, b_bit);
                end
            end
        end
    end

    // Flags stay zero throughout SHIFT because result is only written on the final edge.
    assign busy = (state == SHIFT);
    assign done = (state == DONE);
    assign eq   = result.eq;
    assign gt   = result.gt;
    assign lt   = result.lt;

endmodule

// File: tb/tb_serial_comparator.sv
// Directed self-checking bench for serial_comparator (WIDTH=8).
module tb_serial_comparator;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst, start, bit_valid, a_bit, b_bit;
    logic busy, done, eq, gt, lt;

    int checks   = 0;
    int failures = 0;

    serial_comparator #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bit_valid (bit_valid),
        .a_bit     (a_bit),
        .b_bit     (b_bit),
        .busy      (busy),
        .done      (done),
        .eq        (eq),
        .gt        (gt),
        .lt        (lt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] flags();
        return {eq, gt, lt};
    endfunction

    task automatic start_cmp();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Feeds W pairs MSB first, optionally pausing gap_len cycles after bit gap_bit.
    // Returns the number of edges after the start edge at which done was first seen.
    task automatic feed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int gap_bit, input int gap_len, input logic hold_start,
                        output int done_at);
        int edges;
        edges   = 0;
        done_at = -1;
        for (int i = W - 1; i >= 0; i--) begin
            check({tag, "_busy"}, busy, 1'b1);
            check({tag, "_flags_busy"}, flags(), 3'b000);
            a_bit     = a[i];
            b_bit     = b[i];
            bit_valid = 1'b1;
            start     = hold_start;
            tick();
            edges++;
            if (done && done_at < 0) done_at = edges;
            if (i == gap_bit) begin
                bit_valid = 1'b0;
                a_bit     = ~a_bit;
                b_bit     = ~b_bit;
                for (int g = 0; g < gap_len; g++) begin
                    tick();
                    edges++;
                    if (done && done_at < 0) done_at = edges;
                end
            end
        end
        bit_valid = 1'b0;
        while (done_at < 0 && edges < 40) begin
            tick();
            edges++;
            if (done) done_at = edges;
        end
    endtask

    task automatic full_compare(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                input int gap_bit, input int gap_len, input logic [2:0] exp_flags);
        int lat;
        start_cmp();
        feed(tag, a, b, gap_bit, gap_len, 1'b0, lat);
        // done is seen W edges after the start edge (start cycle to done cycle = W+1 cycles) plus any gaps.
        check({tag, "_latency"}, 32'(lat), 32'(W + gap_len));
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_busy_done"}, busy, 1'b0);
        check({tag, "_flags"}, flags(), exp_flags);
        tick();
        check({tag, "_done_pulse"}, done, 1'b0);
        check({tag, "_flags_idle"}, flags(), exp_flags);
    endtask

    initial begin
        int lat;
        rst = 1'b1; start = 1'b0; bit_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
        tick();
        tick();
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_flags", flags(), 3'b000);
        // start and bit_valid are ignored while reset is held.
        start = 1'b1; bit_valid = 1'b1;
        tick();
        check("reset_over_start", busy, 1'b0);
        rst = 1'b0; start = 1'b0; bit_valid = 1'b0;
        // bit_valid without start does nothing in IDLE.
        bit_valid = 1'b1;
        tick();
        check("idle_ignore_valid", busy, 1'b0);
        bit_valid = 1'b0;

        // {eq, gt, lt}
        full_compare("eq_a5", 8'hA5, 8'hA5, -1, 0, 3'b100);
        full_compare("gt_msb", 8'h80, 8'h7F, -1, 0, 3'b010);
        full_compare("lt_lsb", 8'h12, 8'h13, -1, 0, 3'b001);
        full_compare("gt_gap", 8'hF0, 8'h0F, 4, 3, 3'b010);

        // Reset after 4 accepted bits discards the partial compare.
        start_cmp();
        for (int i = W - 1; i >= W - 4; i--) begin
            a_bit = 1'b1; b_bit = 1'b0; bit_valid = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_flags", flags(), 3'b000);
        tick();
        check("midrst_stay_idle", busy, 1'b0);
        full_compare("lt_after_rst", 8'h01, 8'h02, -1, 0, 3'b001);

        // start held through SHIFT and the DONE cycle is ignored; it is accepted in the first IDLE cycle.
        start_cmp();
        feed("hold", 8'h3C, 8'h5A, -1, 0, 1'b1, lat);
        check("hold_latency", 32'(lat), 32'(W));
        check("hold_done", done, 1'b1);
        check("hold_flags", flags(), 3'b001);
        start = 1'b1;
        tick();
        check("hold_done_drop", busy, 1'b0);
        check("hold_done_pulse", done, 1'b0);
        check("hold_flags_idle", flags(), 3'b001);
        tick();
        start = 1'b0;
        check("b2b_busy", busy, 1'b1);
        check("b2b_flags_clear", flags(), 3'b000);
        feed("b2b", 8'hC3, 8'hC3, -1, 0, 1'b0, lat);
        check("b2b_latency", 32'(lat), 32'(W));
        check("b2b_flags", flags(), 3'b100);
        tick();
        check("b2b_idle", busy | done, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
